fifo_ptr_ctrl: RTL

Parametrised Gray-code pointer controller for one side of the asynchronous FIFO. It keeps a registered binary/Gray pointer pair and synchronises the opposite domain's Gray pointer into its own clock. It produces registered full (write side) or empty (read side), almost, and level status. Two instances, one per clock domain, replace the hand-built pointer logic around the existing Gray conversion.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/gray_sync.sv | 25 ++
 rtl/fifo_ptr_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray conversion, side selectors, depth.
package fifo_pkg;

  localparam int FIFO_WR_SIDE = 0;
  localparam int FIFO_RD_SIDE = 1;
  localparam int FIFO_MAX_W   = 32;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Narrower pointers are zero-extended by the caller; both conversions stay exact.
  function automatic logic [FIFO_MAX_W-1:0] bin2gray(input logic [FIFO_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FIFO_MAX_W-1:0] gray2bin(input logic [FIFO_MAX_W-1:0] g);
    logic [FIFO_MAX_W-1:0] b;
    b[FIFO_MAX_W-1] = g[FIFO_MAX_W-1];
    for (int i = FIFO_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing in from the other clock domain.
module gray_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One side of an async FIFO: registered binary/Gray pointer, synchronised peer pointer,
// and registered full/empty, almost and level status.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_TH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   peer_gray,
  output logic                  accept,
  output logic [ADDR_WIDTH:0]   ptr_bin,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  flag,
  output logic                  almost,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int            PW        = ADDR_WIDTH + 1;
  localparam int            DEPTH     = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] FULL_TH   = PW'(DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] EMPTY_TH  = PW'(ALMOST_TH);
  localparam logic          RST_FLAG  = (MODE == FIFO_RD_SIDE);

  logic [PW-1:0] ptr_bin_q, ptr_bin_d;
  logic [PW-1:0] ptr_gray_q, ptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          flag_q, flag_d;
  logic          almost_q, almost_d;
  logic [PW-1:0] peer_sync;
  logic [PW-1:0] peer_bin;
  logic [PW-1:0] full_gray;

  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .clk (clk),
    .rst (rst),
    .d_i (peer_gray),
    .q_o (peer_sync)
  );

  // A rejected inc leaves the pointer alone, so the limit can never be overrun.
  assign accept = inc & ~flag_q;

  always_comb begin
    peer_bin   = PW'(gray2bin(FIFO_MAX_W'(peer_sync)));
    ptr_bin_d  = ptr_bin_q + PW'(accept);
    ptr_gray_d = PW'(bin2gray(FIFO_MAX_W'(ptr_bin_d)));
    // Full when one lap ahead of the reader: top two Gray bits inverted, rest equal.
    full_gray  = {~peer_sync[PW-1:PW-2], peer_sync[PW-3:0]};
    level_d    = '0;
    flag_d     = 1'b0;
    almost_d   = 1'b0;
    if (MODE == FIFO_WR_SIDE) begin
      level_d  = ptr_bin_d - peer_bin;
      flag_d   = (ptr_gray_d == full_gray);
      almost_d = (level_d >= FULL_TH);
    end else begin
      level_d  = peer_bin - ptr_bin_d;
      flag_d   = (ptr_gray_d == peer_sync);
      almost_d = (level_d <= EMPTY_TH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      level_q    <= '0;
      flag_q     <= RST_FLAG;
      almost_q   <= RST_FLAG;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      level_q    <= level_d;
      flag_q     <= flag_d;
      almost_q   <= almost_d;
    end
  end

  assign ptr_bin  = ptr_bin_q;
  assign ptr_gray = ptr_gray_q;
  assign addr     = ptr_bin_q[ADDR_WIDTH-1:0];
  assign flag     = flag_q;
  assign almost   = almost_q;
  assign level    = level_q;

endmodule
